// File: rtl/phy_rx_pkg.sv
// phy_rx_pkg: shared types and constants for the two-lane PHY receiver.
// Contents: lane alignment state enum, default symbol width, COM idle symbol,
// and a counter-width helper used to size the per-lane counters.
// Optional feature macro used by the importing RTL: PHY_RX_RESYNC_EN.
package phy_rx_pkg;

    localparam int unsigned SYM_W = 8;
    localparam logic [SYM_W-1:0] COM_SYM = 8'hBC;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // bit_cnt width for the default symbol width
    localparam int unsigned BIT_CNT_W = cnt_w(SYM_W);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } lane_state_e;

endpackage

// File: rtl/phy_rx_lane.sv
// phy_rx_lane: one serial-lane deserializer/aligner (MSB first).
// Hunts for the COM idle symbol at any bit offset, confirms byte alignment
// over COM_COUNT consecutive aligned COMs, then reports each byte boundary.
// Ports:
//   clk_i     bit clock, one serial bit sampled per rising edge
//   rst_i     synchronous active-high reset
//   ser_i     serial data in
//   data_o    last received data byte (held across COM periods)
//   valid_o   data_o holds a data byte from the most recent boundary
//   stb_o     one-cycle pulse per byte boundary processed in SYNC
//   active_o  lane is in SYNC
// Optional: PHY_RX_RESYNC_EN adds slip detection and realignment from SYNC.
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter int unsigned      WIDTH     = SYM_W,
    parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_SYM),
    parameter int unsigned      COM_COUNT = 4
`ifdef PHY_RX_RESYNC_EN
    ,
    parameter int unsigned      RESYNC_COUNT = 4
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             stb_o,
    output logic             active_o
);

    localparam int unsigned BCW = (WIDTH == SYM_W) ? BIT_CNT_W : cnt_w(WIDTH);
    localparam int unsigned CCW = cnt_w(COM_COUNT + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    lane_state_e      state_q, state_d;
    // Only the oldest WIDTH-1 bits are kept: the newest bit comes from ser_i.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [CCW-1:0]   com_cnt_q, com_cnt_d, com_cnt_inc;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             stb_q, stb_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] cand;
    logic             is_com;
    logic             boundary;

`ifdef PHY_RX_RESYNC_EN
    localparam int unsigned RCW = cnt_w(RESYNC_COUNT + 1);

    logic [BCW-1:0] rs_off_q, rs_off_d;
    logic [RCW-1:0] rs_cnt_q, rs_cnt_d, rs_cnt_inc;
    logic           rs_hit_q, rs_hit_d;
`endif

    // Next-state and output logic
    always_comb begin
        cand        = {shreg_q, ser_i};
        is_com      = (cand == COM);
        boundary    = (bit_cnt_q == LAST_BIT);
        bit_cnt_inc = boundary ? '0 : bit_cnt_q + BCW'(1);
        com_cnt_inc = com_cnt_q + CCW'(1);

        state_d   = state_q;
        shreg_d   = cand[WIDTH-2:0];
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        stb_d     = 1'b0;
`ifdef PHY_RX_RESYNC_EN
        rs_off_d   = rs_off_q;
        rs_cnt_d   = '0;
        rs_hit_d   = 1'b0;
        rs_cnt_inc = rs_cnt_q + RCW'(1);
`endif

        unique case (state_q)
            SEARCH: begin
                // COM just completed: the next edge is bit 0 of a new byte
                if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CCW'(1);
                    state_d   = ALIGN;
                end
            end

            ALIGN: begin
                bit_cnt_d = bit_cnt_inc;
                if (boundary) begin
                    if (is_com) begin
                        if (com_cnt_inc == CCW'(COM_COUNT)) begin
                            state_d   = SYNC;
                            com_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_inc;
                        end
                    end else begin
                        state_d   = SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end

            SYNC: begin
                bit_cnt_d = bit_cnt_inc;
                if (boundary) begin
                    stb_d = 1'b1;
                    if (is_com) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = cand;
                        valid_d = 1'b1;
                    end
                end
`ifdef PHY_RX_RESYNC_EN
                // Track a COM recurring at one non-boundary offset every byte
                // period; a period without it restarts the count.
                rs_cnt_d = rs_cnt_q;
                rs_hit_d = rs_hit_q;
                if (boundary) begin
                    rs_hit_d = 1'b0;
                    if (!rs_hit_q) begin
                        rs_cnt_d = '0;
                    end
                end else if (is_com) begin
                    rs_hit_d = 1'b1;
                    rs_off_d = bit_cnt_q;
                    if ((rs_cnt_q != '0) && (rs_off_q == bit_cnt_q)) begin
                        rs_cnt_d = rs_cnt_inc;
                    end else begin
                        rs_cnt_d = RCW'(1);
                    end
                    if (rs_cnt_d == RCW'(RESYNC_COUNT)) begin
                        // Slipped COM ends here: realign exactly as SEARCH would
                        state_d   = ALIGN;
                        bit_cnt_d = '0;
                        com_cnt_d = CCW'(1);
                        valid_d   = 1'b0;
                        rs_cnt_d  = '0;
                        rs_hit_d  = 1'b0;
                    end
                end
`endif
            end

            default: begin
                state_d = SEARCH;
            end
        endcase

        active_d = (state_d == SYNC);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SEARCH;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            active_q  <= 1'b0;
`ifdef PHY_RX_RESYNC_EN
            rs_off_q  <= '0;
            rs_cnt_q  <= '0;
            rs_hit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            active_q  <= active_d;
`ifdef PHY_RX_RESYNC_EN
            rs_off_q  <= rs_off_d;
            rs_cnt_q  <= rs_cnt_d;
            rs_hit_q  <= rs_hit_d;
`endif
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign stb_o    = stb_q;
    assign active_o = active_q;

endmodule

// File: rtl/phy_rx.sv
// phy_rx: receive side of the two-lane PHY link. Two independent, identical
// lane deserializers turn serial lanes 0 and 1 back into aligned bytes.
// Ports:
//   clk_8f                 bit clock
//   reset                  synchronous active-high reset
//   ser_in_0 / ser_in_1    serial lane inputs, MSB first
//   data_out_N             lane N last received data byte
//   valid_out_N            lane N data_out_N holds a data byte (not COM)
//   byte_stb_N             lane N one-cycle pulse per byte boundary in SYNC
//   active_N               lane N is in SYNC
// Optional: define PHY_RX_RESYNC_EN to enable slip detection/realignment.
module phy_rx
    import phy_rx_pkg::*;
#(
    parameter int unsigned      WIDTH     = SYM_W,
    parameter logic [WIDTH-1:0] COM       = WIDTH'(COM_SYM),
    parameter int unsigned      COM_COUNT = 4
`ifdef PHY_RX_RESYNC_EN
    ,
    parameter int unsigned      RESYNC_COUNT = 4
`endif
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             ser_in_0,
    input  logic             ser_in_1,
    output logic [WIDTH-1:0] data_out_0,
    output logic             valid_out_0,
    output logic             byte_stb_0,
    output logic             active_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_1,
    output logic             byte_stb_1,
    output logic             active_1
);

    phy_rx_lane #(
        .WIDTH       (WIDTH),
        .COM         (COM),
        .COM_COUNT   (COM_COUNT)
`ifdef PHY_RX_RESYNC_EN
        ,
        .RESYNC_COUNT(RESYNC_COUNT)
`endif
    ) u_lane0 (
        .clk_i   (clk_8f),
        .rst_i   (reset),
        .ser_i   (ser_in_0),
        .data_o  (data_out_0),
        .valid_o (valid_out_0),
        .stb_o   (byte_stb_0),
        .active_o(active_0)
    );

    phy_rx_lane #(
        .WIDTH       (WIDTH),
        .COM         (COM),
        .COM_COUNT   (COM_COUNT)
`ifdef PHY_RX_RESYNC_EN
        ,
        .RESYNC_COUNT(RESYNC_COUNT)
`endif
    ) u_lane1 (
        .clk_i   (clk_8f),
        .rst_i   (reset),
        .ser_i   (ser_in_1),
        .data_o  (data_out_1),
        .valid_o (valid_out_1),
        .stb_o   (byte_stb_1),
        .active_o(active_1)
    );

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx: self-checking bench for phy_rx (default build).
// Serial bits come from per-lane bit queues, one bit per clock; each byte the
// receiver should report in SYNC pushes an expected {valid, data} record onto
// that lane's scoreboard, which a negedge monitor pops on every byte_stb.
module tb_phy_rx;

    localparam logic [7:0] COM = 8'hBC;

    typedef struct packed {
        logic [7:0] sym;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } exp_t;

    logic       clk_8f;
    logic       reset;
    logic       ser_in_0, ser_in_1;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1;
    logic       byte_stb_0, byte_stb_1;
    logic       active_0, active_1;

    logic bq0[$];
    logic bq1[$];
    exp_t sb0[$];
    exp_t sb1[$];

    int tests  = 0;
    int errors = 0;

    phy_rx dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .ser_in_0   (ser_in_0),
        .ser_in_1   (ser_in_1),
        .data_out_0 (data_out_0),
        .valid_out_0(valid_out_0),
        .byte_stb_0 (byte_stb_0),
        .active_0   (active_0),
        .data_out_1 (data_out_1),
        .valid_out_1(valid_out_1),
        .byte_stb_1 (byte_stb_1),
        .active_1   (active_1)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({data_out_0, valid_out_0, byte_stb_0, active_0,
                    data_out_1, valid_out_1, byte_stb_1, active_1});
    endfunction

    task automatic push_bit(input int lane, input logic b);
        if (lane == 0) bq0.push_back(b);
        else           bq1.push_back(b);
    endtask

    task automatic push_sym(input int lane, input logic [7:0] s);
        for (int i = 7; i >= 0; i--) push_bit(lane, s[i]);
    endtask

    task automatic push_exp(input int lane, input logic v, input logic [7:0] d);
        exp_t e;
        e.valid = v;
        e.data  = d;
        if (lane == 0) sb0.push_back(e);
        else           sb1.push_back(e);
    endtask

    // One bit time: drive the next queued bit on each lane (0 when idle)
    task automatic step();
        @(negedge clk_8f);
        ser_in_0 = (bq0.size() != 0) ? bq0.pop_front() : 1'b0;
        ser_in_1 = (bq1.size() != 0) ? bq1.pop_front() : 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_all();
        int guard;
        guard = 0;
        while ((bq0.size() != 0 || bq1.size() != 0) && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) begin
            tests++;
            errors++;
            $display("FAIL run_all_timeout: %0d bits left, required 0", bq0.size() + bq1.size());
        end
    endtask

    task automatic mon_lane(input int lane, input logic [7:0] d, input logic v);
        exp_t e;
        int   left;
        left = (lane == 0) ? sb0.size() : sb1.size();
        if (left == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_stb lane%0d: got data %02h valid %0b, required no strobe", lane, d, v);
        end else begin
            if (lane == 0) e = sb0.pop_front();
            else           e = sb1.pop_front();
            check($sformatf("stb%0d_valid", lane), 32'(v), 32'(e.valid));
            check($sformatf("stb%0d_data", lane), 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk_8f) begin
        if (byte_stb_0 === 1'b1) mon_lane(0, data_out_0, valid_out_0);
        if (byte_stb_1 === 1'b1) mon_lane(1, data_out_1, valid_out_1);
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] t2_bytes[7];
        logic [7:0] last0;

        vecs[0] = '{8'h01, 1'b1, 8'h01};
        vecs[1] = '{8'h02, 1'b1, 8'h02};
        vecs[2] = '{8'h03, 1'b1, 8'h03};
        vecs[3] = '{8'h10, 1'b1, 8'h10};
        vecs[4] = '{8'hBC, 1'b0, 8'h10};
        vecs[5] = '{8'h11, 1'b1, 8'h11};
        vecs[6] = '{8'hBC, 1'b0, 8'h11};
        vecs[7] = '{8'hFF, 1'b1, 8'hFF};

        t2_bytes[0] = 8'h20; t2_bytes[1] = 8'h21; t2_bytes[2] = 8'hBC;
        t2_bytes[3] = 8'h22; t2_bytes[4] = 8'h23; t2_bytes[5] = 8'h24;
        t2_bytes[6] = 8'h25;

        reset    = 1'b1;
        ser_in_0 = 1'b0;
        ser_in_1 = 1'b0;

        // Reset held 3 cycles with lanes toggling
        for (int i = 0; i < 3; i++) begin
            push_bit(0, i[0]);
            push_bit(1, ~i[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", all_outs(), 32'h0);
        end
        reset = 1'b0;

        // Lane 0 locks on 4 aligned COMs, then table-driven data/COM bytes
        for (int i = 0; i < 3; i++) push_sym(0, COM);
        run_all();
        check("active0_after_3com", 32'(active_0), 32'h0);
        push_sym(0, COM);
        run_all();
        check("active0_before_4th_sampled", 32'(active_0), 32'h0);
        for (int i = 0; i < 8; i++) begin
            push_sym(0, vecs[i].sym);
            push_exp(0, vecs[i].exp_valid, vecs[i].exp_data);
        end
        run(2);
        check("active0_after_4th", 32'(active_0), 32'h1);
        run_all();
        check("active1_idle", 32'(active_1), 32'h0);

        // Lane 1 aligns mid-stream after a 3-bit junk prefix; lane 0 keeps going
        last0 = vecs[7].exp_data;
        for (int i = 0; i < 7; i++) begin
            push_sym(0, t2_bytes[i]);
            if (t2_bytes[i] == COM) begin
                push_exp(0, 1'b0, last0);
            end else begin
                push_exp(0, 1'b1, t2_bytes[i]);
                last0 = t2_bytes[i];
            end
        end
        push_bit(1, 1'b1);
        push_bit(1, 1'b1);
        push_bit(1, 1'b0);
        for (int i = 0; i < 5; i++) push_sym(1, COM);
        push_exp(1, 1'b0, 8'h00);
        push_sym(1, 8'h55);
        push_exp(1, 1'b1, 8'h55);
        for (int i = 0; i < 5; i++) push_bit(1, 1'b0);
        run_all();
        run(2);
        check("sb0_left_t2", 32'(sb0.size()), 32'h0);
        check("sb1_left_t2", 32'(sb1.size()), 32'h0);
        check("active1_t2", 32'(active_1), 32'h1);
        check("data1_t2", 32'(data_out_1), 32'h55);
        check("valid1_t2", 32'(valid_out_1), 32'h1);
        check("data0_t2", 32'(data_out_0), 32'h25);
        check("valid0_t2", 32'(valid_out_0), 32'h1);

        // Reset, then ALIGN aborted by a data byte must fall back to SEARCH
        reset = 1'b1;
        run(2);
        check("reset_outs_t3", all_outs(), 32'h0);
        reset = 1'b0;
        push_sym(0, COM);
        push_sym(0, COM);
        push_sym(0, 8'h77);
        push_sym(0, COM);
        push_sym(0, COM);
        push_sym(0, COM);
        push_sym(0, 8'h42);
        run_all();
        run(2);
        check("active0_align_abort", 32'(active_0), 32'h0);
        check("valid0_align_abort", 32'(valid_out_0), 32'h0);
        check("data0_align_abort", 32'(data_out_0), 32'h0);
        check("active1_t3", 32'(active_1), 32'h0);

        // Reset mid-byte in SYNC discards the partial byte; relock from SEARCH
        for (int i = 0; i < 4; i++) push_sym(0, COM);
        push_sym(0, 8'h5A);
        push_exp(0, 1'b1, 8'h5A);
        run_all();
        push_sym(0, 8'h66);
        run(4);
        check("data0_before_midreset", 32'(data_out_0), 32'h5A);
        reset = 1'b1;
        run(2);
        check("midbyte_reset_outs", all_outs(), 32'h0);
        reset = 1'b0;
        bq0.delete();
        for (int i = 0; i < 4; i++) push_sym(0, COM);
        push_sym(0, 8'h99);
        push_exp(0, 1'b1, 8'h99);
        run_all();
        run(2);
        check("data0_relock", 32'(data_out_0), 32'h99);
        check("valid0_relock", 32'(valid_out_0), 32'h1);
        check("active0_relock", 32'(active_0), 32'h1);
        check("sb0_left_end", 32'(sb0.size()), 32'h0);
        check("sb1_left_end", 32'(sb1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
